// File: rtl/fifo_rd_streamer_if.sv
// Signal bundle between the async FIFO read port, fifo_rd_streamer and the downstream stream sink.
// master = the streamer's view; slave = the FIFO/sink environment's view.
interface fifo_rd_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rinc;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output rinc,
    input  rempty,
    input  rdata,
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  rinc,
    output rempty,
    output rdata,
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Read-domain consumer for the async FIFO: pops words, absorbs the one-cycle read latency
// in a 2-entry skid buffer and re-presents them as a framed valid/ready stream.
module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 en,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_cnt,
  fifo_rd_streamer_if.master   strm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [15:0] FPOS_LAST = 16'(FRAME_LEN - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            count;
  logic                  inflight;
  logic [15:0]           fpos;
  logic                  pop_out;
  logic [2:0]            occupancy;

  assign pop_out      = strm.m_valid & strm.m_ready;
  assign strm.m_valid = (count != 2'd0);
  assign strm.m_data  = head_q;
  assign strm.m_last  = (fpos == FPOS_LAST) & strm.m_valid;
  assign busy         = inflight | (count != 2'd0);

  // Slots committed after this edge; a pop is only issued while one is still free,
  // so the buffer can never overflow.
  always_comb begin
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop_out};
    strm.rinc = en & ~strm.rempty & ~rrst & (occupancy < 3'd2);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      inflight <= strm.rinc;
      case ({inflight, pop_out})
        2'b10: begin
          if (count == 2'd0) head_q <= strm.rdata;
          else               tail_q <= strm.rdata;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          count  <= count - 2'd1;
        end
        // Capture and delivery together: head leaves, new word joins at the tail.
        2'b11: begin
          if (count == 2'd1) begin
            head_q <= strm.rdata;
          end else begin
            head_q <= tail_q;
            tail_q <= strm.rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      fpos     <= 16'd0;
      word_cnt <= '0;
    end else if (pop_out) begin
      word_cnt <= word_cnt + CNT_WIDTH'(1);
      fpos     <= (fpos == FPOS_LAST) ? 16'd0 : fpos + 16'd1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Run/stop sequencing; STOP lets in-flight and buffered words drain before going idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN:  if (!en) state_nxt = busy ? STOP : IDLE;
      STOP: begin
        if (en)         state_nxt = RUN;
        else if (!busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: a behavioural FIFO with one-cycle read latency feeds the
// DUT, a negedge monitor checks ordering/framing/counting, and one initial block walks the scenarios.
module tb_fifo_rd_streamer;

  localparam int DW = 8;
  localparam int FL = 16;
  localparam int CW = 32;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          en;
  logic          busy;
  logic [CW-1:0] word_cnt;
  logic          force_empty;

  int checks    = 0;
  int failures  = 0;
  int wptr      = 0;
  int rptr      = 0;
  int rd_idx    = 0;
  int delivered = 0;

  logic [DW-1:0] mem [0:127];
  logic [DW-1:0] popped [$];

  fifo_rd_streamer_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_streamer #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .CNT_WIDTH (CW)
  ) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .en      (en),
    .busy    (busy),
    .word_cnt(word_cnt),
    .strm    (bus)
  );

  always #5 rclk = ~rclk;

  // FIFO read port model: data appears the cycle after an accepted pop.
  assign bus.rempty = (rptr == wptr) || force_empty;

  always @(posedge rclk) begin
    if (bus.rinc) begin
      bus.rdata <= mem[rptr];
      popped.push_back(mem[rptr]);
      rptr <= rptr + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic ready_v, input logic rst_v, input logic empty_v);
    en          = en_v;
    bus.m_ready = ready_v;
    rrst        = rst_v;
    force_empty = empty_v;
  endtask

  task automatic fillFifo(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wptr] = first + DW'(i);
      wptr++;
    end
  endtask

  task automatic nextDrive();
    @(posedge rclk);
    #1;
  endtask

  // Every delivered word must be the next word popped since the last reset, with correct framing.
  always @(negedge rclk) begin
    if (rrst) begin
      rd_idx    = popped.size();
      delivered = 0;
    end else begin
      checkOutput("word_cnt_track", word_cnt, delivered);
      if (bus.rempty) checkOutput("rinc_when_empty", bus.rinc, 1'b0);
      if (bus.m_valid && bus.m_ready) begin
        if (rd_idx < popped.size()) checkOutput("data_order", bus.m_data, popped[rd_idx]);
        else                        checkOutput("data_unpopped", bus.m_valid, 1'b0);
        checkOutput("frame_last", bus.m_last, (delivered % FL) == FL - 1);
        rd_idx++;
        delivered++;
      end
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    fillFifo(8'h01, 32);

    // Reset held with data available and en high
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      checkOutput("rst_rinc", bus.rinc, 1'b0);
      checkOutput("rst_m_valid", bus.m_valid, 1'b0);
      checkOutput("rst_m_data", bus.m_data, 8'h00);
      checkOutput("rst_m_last", bus.m_last, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_word_cnt", word_cnt, 32'd0);
    end

    // Streaming 0x01..0x20 with m_ready high
    nextDrive();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge rclk);
    checkOutput("first_pop", bus.rinc, 1'b1);
    @(negedge rclk);
    checkOutput("fill_m_valid", bus.m_valid, 1'b0);
    checkOutput("fill_busy", busy, 1'b1);
    @(negedge rclk);
    checkOutput("first_m_valid", bus.m_valid, 1'b1);
    checkOutput("first_m_data", bus.m_data, 8'h01);
    for (int i = 0; i < 80 && word_cnt != 32'd32; i++) @(negedge rclk);
    checkOutput("stream_word_cnt", word_cnt, 32'd32);
    @(negedge rclk);
    checkOutput("stream_drained_valid", bus.m_valid, 1'b0);
    checkOutput("stream_drained_busy", busy, 1'b0);
    checkOutput("stream_pops", rptr, 32);

    // Backpressure: only two words may be popped while m_ready is low
    nextDrive();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    fillFifo(8'h21, 16);
    @(negedge rclk);
    checkOutput("bp_pop1", bus.rinc, 1'b1);
    @(negedge rclk);
    checkOutput("bp_pop2", bus.rinc, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      checkOutput("bp_no_rinc", bus.rinc, 1'b0);
      checkOutput("bp_valid", bus.m_valid, 1'b1);
      checkOutput("bp_data_hold", bus.m_data, 8'h21);
      checkOutput("bp_last_hold", bus.m_last, 1'b0);
    end
    checkOutput("bp_two_pops", rptr, 34);
    nextDrive();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60 && word_cnt != 32'd48; i++) @(negedge rclk);
    checkOutput("bp_word_cnt", word_cnt, 32'd48);
    checkOutput("bp_all_popped", rptr, 48);

    // Empty flag toggling every cycle
    nextDrive();
    fillFifo(8'h31, 16);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, (i % 2) == 0);
      #1;
      if ((i % 2) == 0) checkOutput("empty_no_rinc", bus.rinc, 1'b0);
      nextDrive();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60 && word_cnt != 32'd64; i++) @(negedge rclk);
    checkOutput("empty_word_cnt", word_cnt, 32'd64);
    checkOutput("empty_all_popped", rptr, 64);

    // Stop with one word buffered and one in flight, then restart
    nextDrive();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    fillFifo(8'h41, 16);
    nextDrive();
    nextDrive();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge rclk);
    checkOutput("stop_no_rinc", bus.rinc, 1'b0);
    checkOutput("stop_busy", busy, 1'b1);
    checkOutput("stop_head", bus.m_data, 8'h41);
    nextDrive();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge rclk);
    checkOutput("stop_drain1_busy", busy, 1'b1);
    checkOutput("stop_drain1_data", bus.m_data, 8'h41);
    @(negedge rclk);
    checkOutput("stop_drain2_busy", busy, 1'b1);
    checkOutput("stop_drain2_data", bus.m_data, 8'h42);
    @(negedge rclk);
    checkOutput("stop_idle_busy", busy, 1'b0);
    checkOutput("stop_idle_valid", bus.m_valid, 1'b0);
    checkOutput("stop_word_cnt", word_cnt, 32'd66);
    checkOutput("stop_pops", rptr, 66);
    nextDrive();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !(bus.m_valid && bus.m_data == 8'h50); i++) @(negedge rclk);
    checkOutput("restart_data", bus.m_data, 8'h50);
    checkOutput("restart_fpos_last", bus.m_last, 1'b1);
    checkOutput("restart_word_cnt", word_cnt, 32'd79);
    for (int i = 0; i < 20 && word_cnt != 32'd80; i++) @(negedge rclk);
    checkOutput("restart_done", word_cnt, 32'd80);

    // Reset while two words are buffered
    nextDrive();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    fillFifo(8'h51, 16);
    nextDrive();
    nextDrive();
    nextDrive();
    @(negedge rclk);
    checkOutput("pre_rst_valid", bus.m_valid, 1'b1);
    checkOutput("pre_rst_data", bus.m_data, 8'h51);
    checkOutput("pre_rst_rinc", bus.rinc, 1'b0);
    nextDrive();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge rclk);
    checkOutput("midrst_rinc", bus.rinc, 1'b0);
    nextDrive();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge rclk);
    checkOutput("midrst_valid", bus.m_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_last", bus.m_last, 1'b0);
    checkOutput("midrst_word_cnt", word_cnt, 32'd0);
    for (int i = 0; i < 10 && !bus.m_valid; i++) @(negedge rclk);
    checkOutput("midrst_first_data", bus.m_data, 8'h53);
    for (int i = 0; i < 40 && word_cnt != 32'd14; i++) @(negedge rclk);
    checkOutput("midrst_word_cnt_end", word_cnt, 32'd14);
    checkOutput("midrst_all_popped", rptr, 96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
